// File: rtl/magnitude_sqrt_if.sv
// Handshake bundle for magnitude_sqrt: radicand input and root/remainder output channels.
// master drives radicands and accepts results; slave is the root unit.
interface magnitude_sqrt_if #(
   parameter int DOUT_W = 32
);
   logic [2*DOUT_W-1:0] din;
   logic                din_valid;
   logic                din_ready;
   logic [DOUT_W-1:0]   dout;
   logic [DOUT_W:0]     dout_rem;
   logic                dout_valid;
   logic                dout_ready;

   modport master (
      output din, din_valid, dout_ready,
      input  din_ready, dout, dout_rem, dout_valid
   );

   modport slave (
      input  din, din_valid, dout_ready,
      output din_ready, dout, dout_rem, dout_valid
   );
endinterface

// File: rtl/magnitude_sqrt.sv
// Iterative non-restoring integer square root: 2*DOUT_W-bit power in, DOUT_W-bit magnitude out, one bit per clock.
// Optional macro SQRT_ROUND_EN: round the root to nearest (saturating); remainder stays the floor remainder.
module magnitude_sqrt #(
   parameter int DOUT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   magnitude_sqrt_if.slave  bus
);
   localparam int CNT_W = $clog2(DOUT_W);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              r_state;
   logic [2*DOUT_W-1:0] r_rad;
   logic [DOUT_W-1:0]   r_root;
   logic                r_rem_neg;
   logic [DOUT_W-1:0]   r_rem;
   logic [CNT_W-1:0]    r_cnt;
   logic [DOUT_W-1:0]   r_dout;
   logic [DOUT_W:0]     r_dout_rem;
   logic                r_dout_valid;

   logic [DOUT_W+1:0]   w_rem_sh;
   logic [DOUT_W+1:0]   w_trial;
   logic [DOUT_W-1:0]   w_root_nxt;
   logic [DOUT_W:0]     w_rem_fix;
   logic [DOUT_W-1:0]   w_dout;
   logic                w_last;

   // Remainder is kept as sign + low DOUT_W bits; the bits dropped by the shift never carry information.
   always_comb begin
      w_rem_sh   = {r_rem, r_rad[2*DOUT_W-1 -: 2]};
      if (r_rem_neg) begin
         w_trial = w_rem_sh + {r_root, 2'b11};
      end else begin
         w_trial = w_rem_sh - {r_root, 2'b01};
      end
      w_root_nxt = {r_root[DOUT_W-2:0], ~w_trial[DOUT_W+1]};
      w_rem_fix  = w_trial[DOUT_W:0] + (w_trial[DOUT_W+1] ? {w_root_nxt, 1'b1} : '0);
`ifdef SQRT_ROUND_EN
      if ((w_rem_fix > {1'b0, w_root_nxt}) && !(&w_root_nxt)) begin
         w_dout = w_root_nxt + DOUT_W'(1);
      end else begin
         w_dout = w_root_nxt;
      end
`else
      w_dout     = w_root_nxt;
`endif
      w_last     = (r_cnt == CNT_W'(DOUT_W - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_rad        <= '0;
         r_root       <= '0;
         r_rem_neg    <= 1'b0;
         r_rem        <= '0;
         r_cnt        <= '0;
         r_dout       <= '0;
         r_dout_rem   <= '0;
         r_dout_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.din_valid) begin
                  r_rad     <= bus.din;
                  r_root    <= '0;
                  r_rem_neg <= 1'b0;
                  r_rem     <= '0;
                  r_cnt     <= '0;
                  r_state   <= CALC;
               end
            end
            CALC: begin
               r_rad     <= {r_rad[2*DOUT_W-3:0], 2'b00};
               r_root    <= w_root_nxt;
               r_rem_neg <= w_trial[DOUT_W+1];
               r_rem     <= w_trial[DOUT_W-1:0];
               r_cnt     <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_dout       <= w_dout;
                  r_dout_rem   <= w_rem_fix;
                  r_dout_valid <= 1'b1;
                  r_state      <= DONE;
               end
            end
            DONE: begin
               if (bus.dout_ready) begin
                  r_dout_valid <= 1'b0;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.din_ready  = (r_state == IDLE) & ~rst;
   assign bus.dout       = r_dout;
   assign bus.dout_rem   = r_dout_rem;
   assign bus.dout_valid = r_dout_valid;
endmodule

// File: tb/tb_magnitude_sqrt.sv
// Scoreboard bench for magnitude_sqrt: expected roots queued at the accept, compared when results appear.
module tb_magnitude_sqrt;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   typedef struct packed {
      logic [W-1:0] root;
      logic [W:0]   rem;
   } res_t;

   res_t exp_q[$];

   magnitude_sqrt_if #(.DOUT_W(W)) bus();
   magnitude_sqrt #(.DOUT_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Reference: bit-by-bit floor root using full-width squares.
   function automatic res_t model(input logic [2*W-1:0] x);
      res_t          o;
      logic [W-1:0]  r;
      logic [W-1:0]  c;
      logic [2*W-1:0] sq;
      r = '0;
      for (int b = W - 1; b >= 0; b--) begin
         c  = r | (W'(1) << b);
         sq = {{W{1'b0}}, c} * {{W{1'b0}}, c};
         if (sq <= x) r = c;
      end
      o.root = r;
      o.rem  = (W+1)'(x - {{W{1'b0}}, r} * {{W{1'b0}}, r});
      return o;
   endfunction

   function automatic res_t rnd(input res_t f);
      res_t o;
      o = f;
`ifdef SQRT_ROUND_EN
      if ((f.rem > {1'b0, f.root}) && (f.root != {W{1'b1}})) o.root = f.root + W'(1);
`endif
      return o;
   endfunction

   function automatic res_t mk(input logic [W-1:0] root, input logic [W:0] rem);
      res_t o;
      o.root = root;
      o.rem  = rem;
      return o;
   endfunction

   // Presents x until accepted; leaves the bench at the negedge after the accept edge.
   task automatic send(input logic [2*W-1:0] x, input res_t e, input bit track, output bit ok);
      int cyc;
      bus.din       = x;
      bus.din_valid = 1'b1;
      cyc = 0;
      while (!bus.din_ready && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      ok = bus.din_ready;
      if (ok && track) exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      bus.din_valid = 1'b0;
      bus.din       = {$urandom, $urandom};
   endtask

   task automatic wait_result(output bit got, output int cyc);
      cyc = 0;
      while (!bus.dout_valid && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      got = bus.dout_valid;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++;
      if (bus.dout !== '0 || bus.dout_rem !== '0 || bus.dout_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: dout=%h rem=%h valid=%b, want 0/0/0", bus.dout, bus.dout_rem, bus.dout_valid);
      end
      n_tests++;
      if (bus.din_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_din_ready: got %b want 0", bus.din_ready);
      end
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.din_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_din_ready: got %b want 1", bus.din_ready);
      end
   endtask

   task automatic test_zero_latency();
      bit   ok, got;
      int   cyc;
      res_t e;
      send('0, rnd(mk('0, '0)), 1'b1, ok);
      wait_result(got, cyc);
      n_tests++;
      if (!ok || !got || cyc !== 32) begin
         n_fail++;
         $display("FAIL zero_latency: accepted=%b valid=%b cycles=%0d, want 1/1/32", ok, got, cyc);
      end
      e = exp_q.pop_front();
      n_tests++;
      if (bus.dout !== e.root || bus.dout_rem !== e.rem) begin
         n_fail++;
         $display("FAIL zero_result: got %h rem %h, want %h rem %h", bus.dout, bus.dout_rem, e.root, e.rem);
      end
      @(negedge clk);
      n_tests++;
      if (bus.dout_valid !== 1'b0 || bus.din_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_pulse: valid=%b din_ready=%b, want 0/1", bus.dout_valid, bus.din_ready);
      end
   endtask

   task automatic test_values();
      logic [2*W-1:0] xs[8];
      res_t           es[8];
      bit             ok, got;
      int             cyc;
      res_t           e;
      xs[0] = 64'd1_000_000;            es[0] = rnd(mk(32'd1000, 33'd0));
      xs[1] = 64'd15;                   es[1] = rnd(mk(32'd3, 33'd6));
      xs[2] = 64'd12;                   es[2] = rnd(mk(32'd3, 33'd3));
      xs[3] = 64'hFFFF_FFFF_FFFF_FFFF;  es[3] = rnd(mk(32'hFFFF_FFFF, 33'h1_FFFF_FFFE));
      for (int i = 4; i < 8; i++) begin
         xs[i] = {$urandom, $urandom} >> $urandom_range(0, 40);
         es[i] = rnd(model(xs[i]));
      end
      for (int i = 0; i < 8; i++) begin
         send(xs[i], es[i], 1'b1, ok);
         wait_result(got, cyc);
         n_tests++;
         if (!ok || !got) begin
            n_fail++;
            $display("FAIL value_timeout[%0d]: accepted=%b valid=%b", i, ok, got);
         end else begin
            e = exp_q.pop_front();
            n_tests++;
            if (bus.dout !== e.root || bus.dout_rem !== e.rem) begin
               n_fail++;
               $display("FAIL value[%0d] din=%h: got %h rem %h, want %h rem %h",
                        i, xs[i], bus.dout, bus.dout_rem, e.root, e.rem);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      logic [2*W-1:0] x;
      bit             ok, got;
      int             cyc;
      res_t           e;
      x = {$urandom, $urandom};
      bus.dout_ready = 1'b0;
      send(x, rnd(model(x)), 1'b1, ok);
      wait_result(got, cyc);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || !got || bus.dout !== e.root || bus.dout_rem !== e.rem) begin
         n_fail++;
         $display("FAIL bp_result: valid=%b got %h rem %h, want %h rem %h", got, bus.dout, bus.dout_rem, e.root, e.rem);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_tests++;
         if (bus.dout_valid !== 1'b1 || bus.dout !== e.root || bus.dout_rem !== e.rem || bus.din_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: valid=%b dout=%h rem=%h din_ready=%b, want 1/%h/%h/0",
                     i, bus.dout_valid, bus.dout, bus.dout_rem, bus.din_ready, e.root, e.rem);
         end
      end
      bus.dout_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.dout_valid !== 1'b0 || bus.din_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release: valid=%b din_ready=%b, want 0/1", bus.dout_valid, bus.din_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [2*W-1:0] xs[3];
      for (int i = 0; i < 3; i++) xs[i] = {$urandom, $urandom};
      bus.dout_ready = 1'b1;
      fork
         begin : driver
            int cyc;
            for (int i = 0; i < 3; i++) begin
               bus.din_valid = 1'b1;
               cyc = 0;
               while (!bus.din_ready && cyc < 200) begin
                  bus.din = {$urandom, $urandom};
                  @(negedge clk);
                  cyc++;
               end
               if (i > 0) begin
                  n_tests++;
                  if (cyc + 1 !== 34) begin
                     n_fail++;
                     $display("FAIL b2b_interval[%0d]: got %0d cycles, want 34", i, cyc + 1);
                  end
               end
               bus.din = xs[i];
               exp_q.push_back(rnd(model(xs[i])));
               @(posedge clk);
               @(negedge clk);
            end
            bus.din_valid = 1'b0;
         end
         begin : collector
            bit   got;
            int   cyc;
            res_t e;
            for (int i = 0; i < 3; i++) begin
               wait_result(got, cyc);
               n_tests++;
               if (!got || exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL b2b_timeout[%0d]: valid=%b queued=%0d", i, got, exp_q.size());
               end else begin
                  e = exp_q.pop_front();
                  n_tests++;
                  if (bus.dout !== e.root || bus.dout_rem !== e.rem) begin
                     n_fail++;
                     $display("FAIL b2b_result[%0d]: got %h rem %h, want %h rem %h", i, bus.dout, bus.dout_rem, e.root, e.rem);
                  end
               end
               @(negedge clk);
               n_tests++;
               if (bus.dout_valid !== 1'b0) begin
                  n_fail++;
                  $display("FAIL b2b_pulse[%0d]: valid=%b after handshake, want 0", i, bus.dout_valid);
               end
            end
         end
      join
   endtask

   task automatic test_reset_midcalc();
      bit   ok, got;
      int   cyc, seen;
      res_t e;
      send(64'hDEAD_BEEF_0123_4567, mk('0, '0), 1'b0, ok);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.dout_valid) seen++;
      end
      n_tests++;
      if (!ok || seen !== 0) begin
         n_fail++;
         $display("FAIL midcalc_no_result: accepted=%b valid_cycles=%0d, want 1/0", ok, seen);
      end
      n_tests++;
      if (bus.dout !== '0 || bus.dout_rem !== '0) begin
         n_fail++;
         $display("FAIL midcalc_outputs: dout=%h rem=%h, want 0/0", bus.dout, bus.dout_rem);
      end
      send(64'd144, rnd(mk(32'd12, 33'd0)), 1'b1, ok);
      wait_result(got, cyc);
      n_tests++;
      if (!ok || !got) begin
         n_fail++;
         $display("FAIL after_reset_timeout: accepted=%b valid=%b", ok, got);
      end else begin
         e = exp_q.pop_front();
         n_tests++;
         if (bus.dout !== e.root || bus.dout_rem !== e.rem) begin
            n_fail++;
            $display("FAIL after_reset_144: got %h rem %h, want %h rem %h", bus.dout, bus.dout_rem, e.root, e.rem);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      bus.din        = '0;
      bus.din_valid  = 1'b0;
      bus.dout_ready = 1'b1;
      test_reset();
      test_zero_latency();
      test_values();
      test_backpressure();
      test_back_to_back();
      test_reset_midcalc();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
